io_key_capture: RTL and testbench

- Memory-mapped KEY input peripheral on the CPU I/O read path.
- Synchronizes and debounces the four active-low push buttons.
- Latches press events in sticky capture bits and raises a maskable interrupt request.
- The CPU reads status and clears events through the same addr/writedata/memwrite bus used by the LED/HEX registers. The top-level selects this block for KEY-region accesses and routes its read data into the I/O read mux.

---
 rtl/io_key_capture.sv | 100 ++++++++++
 tb/tb_io_key_capture.sv | 136 +++++++++++++
 2 files changed

// File: rtl/io_key_capture.sv
// KEY input peripheral: 2-flop sync + per-key debounce, sticky press capture, maskable irq.
// Stable state updates DEBOUNCE+2 edges after a raw change; combinational read, always-ready bus (no stall).
module io_key_capture #(
  parameter int NKEYS    = 4,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic             sel,
  input  logic             reg_sel,
  input  logic             we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [NKEYS-1:0] level,
  output logic             irq
);

  logic [NKEYS-1:0]            s1_q, s1_d;
  logic [NKEYS-1:0]            s2_q, s2_d;
  logic [NKEYS-1:0]            stable_n_q, stable_n_d;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NKEYS-1:0]            capture_q, capture_d;
  logic [NKEYS-1:0]            mask_q, mask_d;
  logic [NKEYS-1:0]            press;
  logic                        status_wr;
  logic                        mask_wr;
  logic                        unused_wdata;

  assign status_wr    = sel & we & ~reg_sel;
  assign mask_wr      = sel & we & reg_sel;
  assign unused_wdata = ^wdata;

  always_comb begin
    s1_d       = key_n;
    s2_d       = s1_q;
    stable_n_d = stable_n_q;
    cnt_d      = cnt_q;
    press      = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (s2_q[i] == stable_n_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
        stable_n_d[i] = s2_q[i];
        cnt_d[i]      = '0;
        press[i]      = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Clear is applied first so a press landing on the same edge wins.
  always_comb begin
    capture_d = capture_q;
    mask_d    = mask_q;
    if (status_wr) begin
      capture_d = capture_d & ~wdata[8 +: NKEYS];
    end
    capture_d = capture_d | press;
    if (mask_wr) begin
      mask_d = wdata[NKEYS-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '1;
      s2_q       <= '1;
      stable_n_q <= '1;
      cnt_q      <= '0;
      capture_q  <= '0;
      mask_q     <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      stable_n_q <= stable_n_d;
      cnt_q      <= cnt_d;
      capture_q  <= capture_d;
      mask_q     <= mask_d;
    end
  end

  assign level = ~stable_n_q;
  assign irq   = |(capture_q & mask_q);

  always_comb begin
    rdata = '0;
    if (sel) begin
      if (reg_sel) begin
        rdata[NKEYS-1:0] = mask_q;
      end else begin
        rdata[NKEYS-1:0]  = level;
        rdata[8 +: NKEYS] = capture_q;
      end
    end
  end

endmodule

// File: tb/tb_io_key_capture.sv
// Directed bench for io_key_capture with NKEYS=4, DEBOUNCE=4.
module tb_io_key_capture;

  logic        clk;
  logic        reset;
  logic [3:0]  key_n;
  logic        sel;
  logic        reg_sel;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  level;
  logic        irq;

  int passes = 0;
  int total  = 0;
  logic [31:0] rv;

  io_key_capture #(.NKEYS(4), .DEBOUNCE(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sel(sel), .reg_sel(reg_sel),
    .we(we), .wdata(wdata), .rdata(rdata), .level(level), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic rsel, output logic [31:0] v);
    sel = 1'b1; reg_sel = rsel; we = 1'b0;
    #1;
    v = rdata;
    sel = 1'b0; reg_sel = 1'b0;
  endtask

  task automatic wr(input logic rsel, input logic [31:0] d);
    sel = 1'b1; reg_sel = rsel; we = 1'b1; wdata = d;
    tick(1);
    sel = 1'b0; reg_sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  initial begin
    reset = 1'b1; key_n = 4'hF; sel = 1'b0; reg_sel = 1'b0; we = 1'b0; wdata = '0;
    tick(2);
    chk("reset_rdata_unsel", rdata, 32'h0);
    chk("reset_level", {28'h0, level}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    tick(1);
    rd(1'b0, rv); chk("reset_status", rv, 32'h0);
    rd(1'b1, rv); chk("reset_mask", rv, 32'h0);

    // Key 0 press: level must appear on edge 6, not edge 5.
    key_n = 4'hE;
    tick(5);
    chk("k0_edge5_level", {28'h0, level}, 32'h0);
    tick(1);
    chk("k0_edge6_level", {28'h0, level}, 32'h1);
    rd(1'b0, rv); chk("k0_status", rv, 32'h101);
    chk("k0_irq_masked", {31'h0, irq}, 32'h0);

    // Key 1 glitch of 3 cycles is rejected.
    key_n = 4'hC;
    tick(3);
    key_n = 4'hE;
    tick(10);
    chk("glitch_level", {28'h0, level}, 32'h1);
    rd(1'b0, rv); chk("glitch_status", rv, 32'h101);

    // Write strobe without select is ignored.
    reg_sel = 1'b1; we = 1'b1; wdata = 32'hF;
    tick(1);
    reg_sel = 1'b0; we = 1'b0; wdata = '0;
    rd(1'b1, rv); chk("we_nosel_mask", rv, 32'h0);
    chk("we_nosel_irq", {31'h0, irq}, 32'h0);

    wr(1'b1, 32'h1);
    chk("mask1_irq", {31'h0, irq}, 32'h1);
    rd(1'b1, rv); chk("mask1_read", rv, 32'h1);
    wr(1'b0, 32'h100);
    chk("clr0_irq", {31'h0, irq}, 32'h0);
    rd(1'b0, rv); chk("clr0_status", rv, 32'h001);

    // Key 2 press event on the same edge as a clear of capture[2]: set wins.
    key_n = 4'hA;
    tick(5);
    chk("k2_edge5_level", {28'h0, level}, 32'h1);
    sel = 1'b1; reg_sel = 1'b0; we = 1'b1; wdata = 32'h400;
    tick(1);
    sel = 1'b0; we = 1'b0; wdata = '0;
    rd(1'b0, rv); chk("k2_set_wins", rv, 32'h405);
    chk("k2_irq_masked", {31'h0, irq}, 32'h0);
    wr(1'b1, 32'h4);
    chk("k2_irq_unmasked", {31'h0, irq}, 32'h1);

    // Key 3 press, then async reset with captures pending.
    key_n = 4'h2;
    tick(6);
    rd(1'b0, rv); chk("k3_status", rv, 32'hC0D);
    reset = 1'b1;
    #1;
    chk("async_irq", {31'h0, irq}, 32'h0);
    chk("async_level", {28'h0, level}, 32'h0);
    rd(1'b0, rv); chk("async_status", rv, 32'h0);
    rd(1'b1, rv); chk("async_mask", rv, 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    rd(1'b0, rv); chk("redetect_edge5", rv, 32'h0);
    tick(1);
    rd(1'b0, rv); chk("redetect_edge6", rv, 32'hD0D);

    // Release sets nothing; captures remain sticky.
    key_n = 4'hF;
    tick(6);
    rd(1'b0, rv); chk("release_status", rv, 32'hD00);
    chk("release_irq", {31'h0, irq}, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
